// File: rtl/fpdivide_iter.sv
// Iterative signed fixed-point divider: one restoring-division quotient bit per clock,
// then a single fix-up cycle that applies sign, saturation and the status flags.
module fpdivide_iter #(
  parameter int int1     = 6,
  parameter int frac1    = 8,
  parameter int int2     = 6,
  parameter int frac2    = 8,
  parameter int out_int  = 6,
  parameter int out_frac = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic signed [int1+frac1-1:0]       a,
  input  logic signed [int2+frac2-1:0]       b,
  output logic                               busy,
  output logic                               done,
  output logic signed [out_int+out_frac-1:0] quotient,
  output logic                               overflow,
  output logic                               underflow,
  output logic                               div_by_zero
);

  localparam int AW = int1 + frac1;
  localparam int BW = int2 + frac2;
  localparam int OW = out_int + out_frac;
  localparam int NW = int1 + frac1 + out_frac + frac2;
  localparam int DW = BW + frac1;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic signed [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};
  localparam logic [NW-1:0]        QMAX = NW'({1'b0, {(OW-1){1'b1}}});
  localparam logic [NW-1:0]        QLIM = NW'(1) << (OW - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  typedef struct packed {
    logic signed [OW-1:0] q;
    logic                 ov;
    logic                 uf;
  } res_t;

  // Sign, saturation and flag resolution applied once the magnitude quotient is known.
  function automatic res_t sat_fn(input logic [NW-1:0] qm, input logic neg,
                                  input logic bz, input logic a_neg, input logic rem_nz);
    res_t           r;
    logic [OW-1:0]  t;
    r.q = '0;
    r.ov = 1'b0;
    r.uf = 1'b0;
    t = qm[OW-1:0];
    if (bz) begin
      r.q = a_neg ? MINV : MAXV;
    end else if (!neg) begin
      if (qm > QMAX) begin
        r.q  = MAXV;
        r.ov = 1'b1;
      end else begin
        r.q = t;
      end
    end else begin
      if (qm > QLIM) begin
        r.q  = MINV;
        r.ov = 1'b1;
      end else begin
        r.q = -t;
      end
    end
    r.uf = rem_nz & ~r.ov & ~bz;
    return r;
  endfunction

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [NW-1:0]        r_num;
  logic [DW-1:0]        r_rem;
  logic [DW-1:0]        r_den;
  logic                 r_neg;
  logic                 r_a_neg;
  logic                 r_bz;
  logic                 r_busy;
  logic                 r_done;
  logic signed [OW-1:0] r_q;
  logic                 r_ov;
  logic                 r_uf;
  logic                 r_dz;

  logic [AW-1:0]        w_abs_a;
  logic [BW-1:0]        w_abs_b;
  logic [DW:0]          w_trial;
  logic [DW:0]          w_diff;
  logic                 w_ge;
  logic [DW-1:0]        w_rem_nxt;
  logic [NW-1:0]        w_num_nxt;
  res_t                 w_res;

  // Magnitudes stay unsigned at full width so the most negative input does not wrap.
  assign w_abs_a = a[AW-1] ? AW'(-a) : AW'(a);
  assign w_abs_b = b[BW-1] ? BW'(-b) : BW'(b);

  // Restoring step: the numerator register doubles as the quotient shift register.
  assign w_trial   = {r_rem, r_num[NW-1]};
  assign w_diff    = w_trial - {1'b0, r_den};
  assign w_ge      = (w_trial >= {1'b0, r_den});
  assign w_rem_nxt = w_ge ? w_diff[DW-1:0] : w_trial[DW-1:0];
  assign w_num_nxt = {r_num[NW-2:0], w_ge};

  assign w_res = sat_fn(r_num, r_neg, r_bz, r_a_neg, |r_rem);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_num   <= '0;
      r_rem   <= '0;
      r_den   <= '0;
      r_neg   <= 1'b0;
      r_a_neg <= 1'b0;
      r_bz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_ov    <= 1'b0;
      r_uf    <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num   <= NW'(w_abs_a) << (out_frac + frac2);
            r_den   <= DW'(w_abs_b) << frac1;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg   <= a[AW-1] ^ b[BW-1];
            r_a_neg <= a[AW-1];
            r_bz    <= (b == '0);
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_num <= w_num_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(NW - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_q     <= w_res.q;
          r_ov    <= w_res.ov;
          r_uf    <= w_res.uf;
          r_dz    <= r_bz;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_q;
  assign overflow    = r_ov;
  assign underflow   = r_uf;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_fpdivide_iter.sv
// Bench for fpdivide_iter: arithmetic reference model with a latency countdown,
// per-cycle output comparison, directed vectors and randomized divides.
module tb_fpdivide_iter;

  localparam int NW = 30;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic signed [13:0] a = '0;
  logic signed [13:0] b = '0;
  logic               busy, done, overflow, underflow, div_by_zero;
  logic signed [13:0] quotient;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  fpdivide_iter dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: exact integer division of the scaled magnitudes, then sign and clamp.
  function automatic void model(input int av, input int bv, output int q,
                                output bit ov, output bit uf, output bit dz);
    longint n, d, qm, r;
    bit neg;
    q = 0; ov = 0; uf = 0; dz = 0;
    if (bv == 0) begin
      dz = 1;
      q  = (av < 0) ? -8192 : 8191;
      return;
    end
    n   = longint'(av < 0 ? -av : av) * 65536;
    d   = longint'(bv < 0 ? -bv : bv) * 256;
    qm  = n / d;
    r   = n % d;
    neg = (av < 0) != (bv < 0);
    if (!neg) begin
      if (qm > 8191) begin q = 8191; ov = 1; end
      else q = int'(qm);
    end else begin
      if (qm > 8192) begin q = -8192; ov = 1; end
      else q = -int'(qm);
    end
    uf = (r != 0) && !ov;
  endfunction

  int m_cnt = 0;
  bit m_busy = 0, m_done = 0, m_ov = 0, m_uf = 0, m_dz = 0;
  int m_q = 0;
  int p_q;
  bit p_ov, p_uf, p_dz;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_busy = 0; m_done = 0; m_q = 0; m_ov = 0; m_uf = 0; m_dz = 0;
    end else begin
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1; m_busy = 0;
          m_q = p_q; m_ov = p_ov; m_uf = p_uf; m_dz = p_dz;
        end
      end else if (start) begin
        m_cnt  = NW + 1;
        m_busy = 1;
        model(int'(a), int'(b), p_q, p_ov, p_uf, p_dz);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      total++;
      if (busy !== m_busy || done !== m_done || int'(quotient) !== m_q ||
          overflow !== m_ov || underflow !== m_uf || div_by_zero !== m_dz) begin
        bad++;
        $display("FAIL cycle t=%0t got busy=%b done=%b q=%0d ov=%b uf=%b dz=%b want busy=%b done=%b q=%0d ov=%b uf=%b dz=%b",
                 $time, busy, done, quotient, overflow, underflow, div_by_zero,
                 m_busy, m_done, m_q, m_ov, m_uf, m_dz);
      end
    end
  end

  task automatic pulse_start(input int av, input int bv);
    @(posedge clk); #2;
    a = 14'(av); b = 14'(bv); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    a = 14'($urandom); b = 14'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL done-timeout got no done within 40 cycles, want done");
    end
  endtask

  task automatic check_lit(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic run_vec(input string nm, input int av, input int bv, input int eq,
                         input bit eov, input bit euf, input bit edz);
    int q; bit ov, uf, dz, ok;
    model(av, bv, q, ov, uf, dz);
    check_lit({nm, "-model"}, {q, 29'(0), ov, uf, dz}, {eq, 29'(0), eov, euf, edz});
    pulse_start(av, bv);
    wait_done(ok);
    if (ok) check_lit(nm, {int'(quotient), 29'(0), overflow, underflow, div_by_zero},
                      {eq, 29'(0), eov, euf, edz});
  endtask

  initial begin
    int q; bit ov, uf, dz, ok;
    int av, bv;
    repeat (3) @(posedge clk);
    #2;
    check_lit("reset-state", {busy, done, overflow, underflow, div_by_zero, 14'(quotient)}, 0);
    reset = 1'b1;
    chk_en = 1'b1;

    run_vec("v1-1.5/0.5", 384, 128, 768, 0, 0, 0);
    run_vec("v2a-neg", -768, 512, -384, 0, 0, 0);
    run_vec("v2b-min-exact", -8192, 256, -8192, 0, 0, 0);
    run_vec("v3a-sat-pos", 7936, 64, 8191, 1, 0, 0);
    run_vec("v3b-sat-negneg", -8192, -256, 8191, 1, 0, 0);
    run_vec("v4a-inexact", 256, 768, 85, 0, 1, 0);
    run_vec("v4b-inexact-neg", -256, 768, -85, 0, 1, 0);
    run_vec("v5a-dz-neg", -256, 0, -8192, 0, 0, 1);
    run_vec("v5b-dz-zero", 0, 0, 8191, 0, 0, 1);
    run_vec("zero-neg-div", 0, -300, 0, 0, 0, 0);
    run_vec("sat-neg", 7936, -64, -8192, 1, 0, 0);

    // Second start while busy must be ignored; the per-cycle compare sees any extra done.
    pulse_start(1000, 300);
    repeat (3) @(posedge clk);
    #2; a = 14'(50); b = 14'(7); start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    wait_done(ok);
    model(1000, 300, q, ov, uf, dz);
    if (ok) check_lit("ignore-restart", int'(quotient), q);
    repeat (5) @(posedge clk);

    // Reset mid-operation aborts with all outputs cleared immediately.
    pulse_start(-5000, 333);
    repeat (8) @(posedge clk);
    #2; reset = 1'b0;
    #1;
    check_lit("reset-abort", {busy, done, overflow, underflow, div_by_zero, 14'(quotient)}, 0);
    repeat (2) @(posedge clk);
    #2; reset = 1'b1;
    run_vec("after-reset", -5000, 333, -3843, 0, 1, 0);

    for (int i = 0; i < 200; i++) begin
      av = int'($signed(14'($urandom)));
      case ($urandom_range(0, 3))
        0: bv = 0;
        1: bv = $urandom_range(0, 1) ? int'($urandom_range(1, 64)) : -int'($urandom_range(1, 64));
        default: bv = int'($signed(14'($urandom)));
      endcase
      model(av, bv, q, ov, uf, dz);
      pulse_start(av, bv);
      wait_done(ok);
      if (ok) check_lit("random-q", int'(quotient), q);
      if ($urandom_range(0, 3) == 0) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpdivide_iter.md
Name: fpdivide_iter

Overview:
- Iterative signed fixed-point divider; the inverse companion of the team's fixed-point multiplier. Uses the same Q-format parameter style.
- Computes a/b one quotient bit per clock with a start/done handshake.
- Saturates on overflow and flags inexact results and divide-by-zero.
- Sits in datapaths that need normalisation or scaling where a single-cycle divider does not meet area.

Parameters:
- int1, 6, integer bits of dividend a (incl. sign)
- frac1, 8, fraction bits of dividend a
- int2, 6, integer bits of divisor b (incl. sign)
- frac2, 8, fraction bits of divisor b
- out_int, 6, integer bits of quotient (incl. sign)
- out_frac, 8, fraction bits of quotient
- Derived (localparam): OW = out_int+out_frac; NW = int1+frac1+out_frac+frac2 (iteration count)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  int1+frac1  signed dividend, two's complement
- b  input  int2+frac2  signed divisor, two's complement
- busy  output  1  high from the edge accepting start until done
- done  output  1  one-cycle pulse; quotient and flags valid
- quotient  output  OW  signed result, held until next done
- overflow  output  1  result saturated (held with quotient)
- underflow  output  1  nonzero remainder, precision lost (held)
- div_by_zero  output  1  b was zero (held)

Behaviour:
- Reset (async, reset=0):
  - All outputs 0; FSM to IDLE; internal registers cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, CALC, FIX.
  - IDLE with start=1 at edge k: latch |a|, |b|, and sign = a_msb XOR b_msb. busy=1. Go to CALC with the iteration counter at 0.
  - start while busy or in FIX: ignored, no queueing.
  - CALC: one restoring-division step per edge. Numerator N = |a|<<(out_frac+frac2); denominator D = |b|<<frac1; magnitude quotient Qm = floor(N/D). Go to FIX after exactly NW steps (edges k+1..k+NW).
  - FIX at edge k+NW+1: apply sign and saturation, register quotient and flags, done=1, busy=0. Next state IDLE.
  - done is low at all other times.
  - Fixed latency: done is visible after the (NW+1)th edge following the start edge. With defaults, NW=30, so 31 edges.
- Abs of the most negative input must not wrap: magnitude registers are int+frac bits wide, unsigned.
- Rounding: truncate toward zero (magnitude truncation, then negate).
- Saturation limits: MAX = 2^(OW-1)-1, MIN = -2^(OW-1).
  - Positive result with Qm > MAX → quotient=MAX, overflow=1.
  - Negative result with Qm > 2^(OW-1) → quotient=MIN, overflow=1.
  - Negative result with Qm = 2^(OW-1) exactly → MIN, overflow=0.
- underflow = (remainder != 0) AND NOT overflow.
- Zero quotient after negation is 0 (no negative zero).
- b = 0:
  - div_by_zero=1, overflow=0, underflow=0.
  - quotient = MAX if a ≥ 0, MIN if a < 0.
  - Same latency; the CALC steps still run and their result is discarded.
- On done, all three flags are updated together; the previous values are held until the next done.
- a and b may change after the start edge without effect.

Test Plan:
Defaults used throughout (Q6.8 inputs, Q6.8 output, OW=14).
1. a=384 (1.5), b=128 (0.5), start pulse → after 31 edges done=1, quotient=768 (3.0), all flags 0; busy high for exactly 31 cycles.
2. a=-768 (-3.0), b=512 (2.0) → quotient=-384 (0x3E80), flags 0. Then a=-8192 (-32.0), b=256 → quotient=-8192 (0x2000), overflow=0.
3. a=7936 (31.0), b=64 (0.25) → quotient=8191 (0x1FFF), overflow=1. Then a=-8192, b=-256 → quotient=8191, overflow=1.
4. a=256 (1.0), b=768 (3.0) → quotient=85, underflow=1, overflow=0. Then a=-256, b=768 → quotient=-85, underflow=1.
5. a=-256, b=0 → quotient=-8192, div_by_zero=1, other flags 0. Then a=0, b=0 → quotient=8191, div_by_zero=1.
6. Start a divide, pulse start again at edge k+5 → ignored, single done at k+31. Start a divide, assert reset at edge k+10 → all outputs 0 immediately, no done. New start after reset release → correct result.
